// File: rtl/imm_gen_pipe.sv
// Immediate generator for RV32I/RV64I formats, registered behind a valid/ready
// handshake with a two-entry (output + skid) buffer that carries a sideband tag.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] SRC_I     = 3'b000;
    localparam logic [2:0] SRC_S     = 3'b001;
    localparam logic [2:0] SRC_B     = 3'b010;
    localparam logic [2:0] SRC_J     = 3'b011;
    localparam logic [2:0] SRC_U     = 3'b100;
    localparam logic [2:0] SRC_SHAMT = 3'b101;
    localparam logic [2:0] SRC_ZIMM  = 3'b110;

    logic             unused_opcode;
    logic [31:0]      imm32;
    logic             imm_sx;
    logic             imm_illegal;
    logic [XLEN-1:0]  imm_ext;
    logic             accept;
    logic             transfer;

    logic             out_valid_d,   out_valid_q;
    logic [XLEN-1:0]  out_imm_d,     out_imm_q;
    logic [TAG_W-1:0] out_tag_d,     out_tag_q;
    logic             out_illegal_d, out_illegal_q;
    logic             skid_valid_d,  skid_valid_q;
    logic [XLEN-1:0]  skid_imm_d,    skid_imm_q;
    logic [TAG_W-1:0] skid_tag_d,    skid_tag_q;
    logic             skid_illegal_d, skid_illegal_q;

    assign unused_opcode = ^instr[6:0];

    // Format decode: every format is built as a 32-bit value, then widened to XLEN
    always_comb begin
        imm32       = 32'd0;
        imm_sx      = 1'b0;
        imm_illegal = 1'b0;
        case (imm_src)
            SRC_I: begin
                imm32  = {{20{instr[31]}}, instr[31:20]};
                imm_sx = 1'b1;
            end
            SRC_S: begin
                imm32  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                imm_sx = 1'b1;
            end
            SRC_B: begin
                imm32  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                imm_sx = 1'b1;
            end
            SRC_J: begin
                imm32  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                imm_sx = 1'b1;
            end
            SRC_U: begin
                imm32  = {instr[31:12], 12'd0};
                imm_sx = 1'b1;
            end
            SRC_SHAMT: begin
                if (XLEN == 64) begin
                    imm32 = {26'd0, instr[25:20]};
                end else begin
                    imm32 = {27'd0, instr[24:20]};
                end
            end
            SRC_ZIMM: imm32 = {27'd0, instr[19:15]};
            default:  imm_illegal = 1'b1;
        endcase
        if (imm_sx) begin
            imm_ext = XLEN'($signed(imm32));
        end else begin
            imm_ext = XLEN'(imm32);
        end
    end

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & ~skid_valid_q;
    assign transfer = out_valid_q & out_ready;

    // Next-state for the output/skid pair, indexed by their valid bits
    always_comb begin
        out_valid_d    = out_valid_q;
        out_imm_d      = out_imm_q;
        out_tag_d      = out_tag_q;
        out_illegal_d  = out_illegal_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_tag_d     = skid_tag_q;
        skid_illegal_d = skid_illegal_q;
        case ({out_valid_q, skid_valid_q})
            2'b00: begin
                if (accept) begin
                    out_valid_d   = 1'b1;
                    out_imm_d     = imm_ext;
                    out_tag_d     = in_tag;
                    out_illegal_d = imm_illegal;
                end else begin
                    out_valid_d   = 1'b0;
                end
            end
            2'b10: begin
                if (accept && transfer) begin
                    out_imm_d     = imm_ext;
                    out_tag_d     = in_tag;
                    out_illegal_d = imm_illegal;
                end else if (accept) begin
                    skid_valid_d   = 1'b1;
                    skid_imm_d     = imm_ext;
                    skid_tag_d     = in_tag;
                    skid_illegal_d = imm_illegal;
                end else if (transfer) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            2'b11: begin
                if (transfer) begin
                    out_imm_d     = skid_imm_q;
                    out_tag_d     = skid_tag_q;
                    out_illegal_d = skid_illegal_q;
                    skid_valid_d  = 1'b0;
                end else begin
                    skid_valid_d  = 1'b1;
                end
            end
            // Unreachable pair: drop everything rather than emit an orphaned skid beat
            default: begin
                out_valid_d  = 1'b0;
                skid_valid_d = 1'b0;
            end
        endcase
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_imm_q      <= '0;
            out_tag_q      <= '0;
            out_illegal_q  <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= '0;
            skid_tag_q     <= '0;
            skid_illegal_q <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_imm_q      <= out_imm_d;
            out_tag_q      <= out_tag_d;
            out_illegal_q  <= out_illegal_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_tag_q     <= skid_tag_d;
            skid_illegal_q <= skid_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parameterised immediate generator for the next-generation core datapath. It decodes all RV32I/RV64I immediate formats, including U-type, shift-amount and CSR zero-immediates. Each result is registered behind a valid/ready handshake with a 2-entry skid buffer, so decode can be split across a pipeline boundary without losing throughput. A sideband tag travels with each instruction so downstream stages can match results to their source.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 8, width of the sideband tag carried alongside each immediate.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  instr/imm_src/in_tag are valid this cycle.
- in_ready  output  1  block can accept a beat this cycle.
- instr  input  32  full instruction word; bits [6:0] are ignored.
- imm_src  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 SHAMT, 110 ZIMM, 111 illegal.
- in_tag  input  TAG_W  opaque sideband, passed through unchanged.
- out_valid  output  1  out_imm/out_tag/out_illegal hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_imm  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of the beat currently on the output.
- out_illegal  output  1  the beat was issued with imm_src=111.

## Operation
- Extension rules. "sx" means sign-extend from instr[31] to XLEN; "zx" means zero-extend to XLEN.
  - I: sx(instr[31:20]).
  - S: sx({instr[31:25], instr[11:7]}).
  - B: sx({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - J: sx({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - U: sx({instr[31:12], 12'b0}). For XLEN=32 this is simply the 32-bit value.
  - SHAMT: zx(instr[24:20]) when XLEN=32; zx(instr[25:20]) when XLEN=64.
  - ZIMM: zx(instr[19:15]).
  - Illegal (111): out_imm=0 and out_illegal=1. The beat still flows through the pipeline normally.
- Computation is combinational on the input side. The result is captured into the output register or the skid register on acceptance.
- Storage consists of an output register (OUT) and a skid register (SKID). Occupancy runs 0..2 and is tracked as two valid bits.
- Handshake rules:
  - Accept = in_valid & in_ready.
  - Transfer = out_valid & out_ready.
  - in_ready = ~SKID.valid. It is a registered-state function only and has no combinational path from out_ready.
- State cases (OUT.valid, SKID.valid):
  - (0,0): accept loads OUT.
  - (1,0):
    - Accept with transfer: OUT is reloaded with the new beat.
    - Accept without transfer: the beat goes to SKID.
    - Transfer only: OUT empties.
  - (1,1):
    - No accept is possible.
    - Transfer moves SKID to OUT and SKID empties.
    - No transfer: hold.
  - (0,1) is unreachable. The verification engineer asserts on it.
- Ordering is strictly FIFO. Each accepted beat appears on the output exactly once.
- out_* holds stable while out_valid=1 and out_ready=0.
- Parameter check: XLEN other than 32 or 64 must cause an elaboration-time error.

## Timing
- Reset: out_valid=0, out_imm=0, out_tag=0, out_illegal=0, both valid bits cleared, in_ready=1 from the first cycle after reset deasserts.
- Reset asserted mid-operation discards all stored beats on the next edge. Inputs presented during reset are ignored.
- Latency: a beat accepted in cycle N is visible at the output in cycle N+1 when OUT is empty or draining.
- Throughput: 1 beat/cycle while out_ready is held high.
- Backpressure:
  - With out_ready=0, at most 2 beats are absorbed.
  - in_ready falls in the cycle after the second accept.
  - in_ready rises in the cycle after the first transfer that empties SKID.
- Simultaneous accept and transfer in state (1,0) keeps occupancy at 1 with no bubble.

## Test plan
- Formats, XLEN=32, out_ready=1:
  - I 0xFFF00093 → 0xFFFFFFFF.
  - S 0xFE20AE23 → 0xFFFFFFFC.
  - B 0xFE000CE3 → 0xFFFFFFF8.
  - J 0x0010006F → 0x00000800.
  - U 0x123450B7 → 0x12345000.
  - ZIMM 0x000F8000 → 0x0000001F.
  - Each result appears one cycle after acceptance.
- XLEN=64:
  - U 0x800000B7 → 0xFFFFFFFF80000000.
  - SHAMT 0x03F01013 → 0x3F. With XLEN=32 the same word → 0x1F.
- Illegal: imm_src=111, tag 0x5A → out_imm=0, out_illegal=1, out_tag=0x5A. The next legal beat must show out_illegal=0.
- Backpressure:
  - Hold out_ready=0 and drive 3 beats with tags 1, 2, 3. Tags 1 and 2 are accepted; in_ready=0 from the cycle after the second accept; tag 3 is held.
  - Raise out_ready. Output order must be 1, 2, 3 with no duplicates or drops.
  - out_imm must stay stable while stalled.
- Streaming: 100 random beats with random in_valid/out_ready. A scoreboard must match every beat in order, and (0,1) must never occur.
- Reset mid-operation: with 2 beats held, assert reset for 1 cycle. Afterwards out_valid=0, in_ready=1, and a new beat emerges one cycle after acceptance.
